// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Forwarding and load-use hazard controller for the in-order pipeline.
//   Keeps a shift-register record of every in-flight instruction from EX
//   (record 0) through the last result stage (record STAGES-1). From those
//   records it derives the EX operand forward selects, MEM store-data
//   forwarding and the ID load-use stall. It also keeps a saturating count
//   of stall cycles.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   id_*            decoded fields of the instruction sitting in ID
//   flush           kill ID and EX (taken branch resolved in EX)
//   stall           hold PC/IF/ID and insert a bubble into EX
//   fwd_a, fwd_b    EX operand source: 0 = regfile, k = result of stage k
//   fwd_c           MEM store data taken from the stage-2 result
//   ex_valid        record 0 holds a live instruction
//   stall_cnt       saturating count of stall cycles
module fwd_hazard_ctrl #(
  parameter int unsigned AW       = 4,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CW       = 16,
  localparam int unsigned FW      = $clog2(STAGES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [AW-1:0] id_rd,
  input  logic          id_wen,
  input  logic          id_load,
  input  logic          id_store,
  input  logic          flush,
  output logic          stall,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic          fwd_c,
  output logic          ex_valid,
  output logic [CW-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic          use_rs;
    logic          use_rt;
    logic          wen;
    logic          load;
    logic          store;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
  } rec_t;

  rec_t              rec_q [STAGES];
  rec_t              rec_d [STAGES];
  logic [STAGES-1:0] live;
  logic              stall_hit;
  logic              stall_int;
  logic [CW-1:0]     stall_cnt_q;
  logic [CW-1:0]     stall_cnt_d;

  // A record is a live writer when it will actually update the register file.
  always_comb begin
    live = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      live[k] = rec_q[k].valid & rec_q[k].wen & ((ZERO_REG == 0) | (rec_q[k].rd != '0));
    end
  end

  // Load-use: a load whose data is not yet available by the time the consumer
  // reaches EX must hold ID. Only stages 0..LOAD_LAT-2 can be too early.
  always_comb begin
    stall_hit = 1'b0;
    for (int j = 0; j < int'(STAGES); j++) begin
      if ((j + 2 <= int'(LOAD_LAT)) && live[j] && rec_q[j].load &&
          ((id_use_rs && (id_rs == rec_q[j].rd)) ||
           (id_use_rt && (id_rt == rec_q[j].rd)))) begin
        stall_hit = 1'b1;
      end
    end
    // flush wins over stall; reset forces it low too
    stall_int = ~rst & id_valid & ~flush & stall_hit;
  end

  assign stall = stall_int;

  // Next-state of the record chain: lower stages always advance.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      rec_d[k] = '0;
    end
    if (id_valid && !stall_int && !flush) begin
      rec_d[0].valid  = 1'b1;
      rec_d[0].use_rs = id_use_rs;
      rec_d[0].use_rt = id_use_rt;
      rec_d[0].wen    = id_wen;
      rec_d[0].load   = id_load;
      rec_d[0].store  = id_store;
      rec_d[0].rs     = id_rs;
      rec_d[0].rt     = id_rt;
      rec_d[0].rd     = id_rd;
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      rec_d[k] = rec_q[k-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_int && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        rec_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        rec_q[k] <= rec_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign ex_valid  = rec_q[0].valid;

  // Operand forwarding: walk from the oldest stage towards EX so the nearest
  // matching writer overwrites any older one. Loads whose data is not ready
  // yet are skipped; the stall logic keeps a consumer from meeting them.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = int'(STAGES) - 1; k >= 1; k--) begin
      if (live[k] && !(rec_q[k].load && (k < int'(LOAD_LAT))) && rec_q[0].valid) begin
        if (rec_q[0].use_rs && (rec_q[k].rd == rec_q[0].rs)) begin
          fwd_a = FW'(k);
        end
        if (rec_q[0].use_rt && (rec_q[k].rd == rec_q[0].rt)) begin
          fwd_b = FW'(k);
        end
      end
    end
  end

  // Store data forwarding into MEM; the store itself never writes, so only
  // the stage-2 writer can be the source.
  if (STAGES >= 3) begin : g_fwd_c
    assign fwd_c = rec_q[1].valid & rec_q[1].store & live[2] & (rec_q[2].rd == rec_q[1].rt);
  end else begin : g_no_fwd_c
    assign fwd_c = 1'b0;
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: three configurations (default, ZERO_REG=0,
// STAGES=4/LOAD_LAT=3/CW=3) share one stimulus stream and are compared every
// cycle against an instruction-level pipeline model.
module tb_fwd_hazard_ctrl;

  localparam int AW = 4;
  localparam int NC = 3;

  int cfg_st [NC] = '{3, 3, 4};
  int cfg_ll [NC] = '{2, 2, 3};
  int cfg_zr [NC] = '{1, 0, 1};
  int cfg_cw [NC] = '{16, 16, 3};

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_use_rs, id_use_rt, id_wen, id_load, id_store, flush;
  logic [AW-1:0] id_rs, id_rt, id_rd;

  logic        stall0, stall1, stall2;
  logic [1:0]  fa0, fa1, fa2, fb0, fb1, fb2;
  logic        fc0, fc1, fc2, ev0, ev1, ev2;
  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;

  always #5 clk = ~clk;

  fwd_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wen(id_wen),
    .id_load(id_load), .id_store(id_store), .flush(flush), .stall(stall0),
    .fwd_a(fa0), .fwd_b(fb0), .fwd_c(fc0), .ex_valid(ev0), .stall_cnt(cnt0)
  );

  fwd_hazard_ctrl #(.ZERO_REG(0)) u_dut_z0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wen(id_wen),
    .id_load(id_load), .id_store(id_store), .flush(flush), .stall(stall1),
    .fwd_a(fa1), .fwd_b(fb1), .fwd_c(fc1), .ex_valid(ev1), .stall_cnt(cnt1)
  );

  fwd_hazard_ctrl #(.STAGES(4), .LOAD_LAT(3), .CW(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wen(id_wen),
    .id_load(id_load), .id_store(id_store), .flush(flush), .stall(stall2),
    .fwd_a(fa2), .fwd_b(fb2), .fwd_c(fc2), .ex_valid(ev2), .stall_cnt(cnt2)
  );

  // Model: one instruction slot per pipeline stage, per configuration.
  typedef struct packed {
    bit valid, use_rs, use_rt, wen, load, store;
    int rs, rt, rd;
  } ins_t;

  ins_t pipe [NC][4];
  int   m_cnt [NC];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(ins_t i, int c);
    return i.valid && i.wen && (cfg_zr[c] == 0 || i.rd != 0);
  endfunction

  function automatic bit exp_stall(int c);
    if (rst || !id_valid || flush) return 1'b0;
    // a load at stage j delivers data at stage LOAD_LAT; too early if j < LOAD_LAT-1
    for (int j = 0; j <= cfg_ll[c] - 2; j++) begin
      ins_t p = pipe[c][j];
      if (writes(p, c) && p.load &&
          ((id_use_rs && int'(id_rs) == p.rd) || (id_use_rt && int'(id_rt) == p.rd)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int exp_fwd(int c, bit side_b);
    ins_t e = pipe[c][0];
    int   src = side_b ? e.rt : e.rs;
    bit   use_it = side_b ? e.use_rt : e.use_rs;
    if (!e.valid || !use_it) return 0;
    for (int k = 1; k < cfg_st[c]; k++) begin
      if (writes(pipe[c][k], c) && pipe[c][k].rd == src &&
          !(pipe[c][k].load && k < cfg_ll[c]))
        return k;
    end
    return 0;
  endfunction

  function automatic int exp_fwdc(int c);
    if (cfg_st[c] < 3) return 0;
    return int'(pipe[c][1].valid && pipe[c][1].store && writes(pipe[c][2], c) &&
                pipe[c][2].rd == pipe[c][1].rt);
  endfunction

  task automatic check_cfg(input int c, input string p, input int st, input int fa,
                           input int fb, input int fc, input int ev, input int cnt);
    check_eq({p, "_stall"}, st, int'(exp_stall(c)));
    check_eq({p, "_fwd_a"}, fa, exp_fwd(c, 1'b0));
    check_eq({p, "_fwd_b"}, fb, exp_fwd(c, 1'b1));
    check_eq({p, "_fwd_c"}, fc, exp_fwdc(c));
    check_eq({p, "_ex_valid"}, ev, int'(pipe[c][0].valid));
    check_eq({p, "_stall_cnt"}, cnt, m_cnt[c]);
  endtask

  task automatic step_model();
    for (int c = 0; c < NC; c++) begin
      bit   s = exp_stall(c);
      ins_t n = '0;
      if (rst) begin
        for (int k = 0; k < 4; k++) pipe[c][k] = '0;
        m_cnt[c] = 0;
      end else begin
        for (int k = cfg_st[c] - 1; k >= 1; k--) pipe[c][k] = pipe[c][k-1];
        if (id_valid && !s && !flush) begin
          n.valid = 1'b1;  n.use_rs = id_use_rs; n.use_rt = id_use_rt;
          n.wen = id_wen;  n.load = id_load;     n.store = id_store;
          n.rs = int'(id_rs); n.rt = int'(id_rt); n.rd = int'(id_rd);
        end
        pipe[c][0] = n;
        if (s && m_cnt[c] < (1 << cfg_cw[c]) - 1) m_cnt[c]++;
      end
    end
  endtask

  // One clock cycle: drive ID at the falling edge, check, then advance the model.
  task automatic cyc(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                     input int rd, input bit wen, input bit ld, input bit st,
                     input bit fl, input bit r, input bit chk);
    @(negedge clk);
    id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_use_rs = urs; id_use_rt = urt;
    id_rd = AW'(rd); id_wen = wen; id_load = ld; id_store = st; flush = fl; rst = r;
    #1;
    if (chk) begin
      check_cfg(0, "def", int'(stall0), int'(fa0), int'(fb0), int'(fc0), int'(ev0), int'(cnt0));
      check_cfg(1, "z0", int'(stall1), int'(fa1), int'(fb1), int'(fc1), int'(ev1), int'(cnt1));
      check_cfg(2, "l3", int'(stall2), int'(fa2), int'(fb2), int'(fc2), int'(ev2), int'(cnt2));
    end
    step_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // ALU op rd <- rs op rt
  task automatic alu(input int rd, input int rs, input int rt);
    cyc(1, rs, rt, 1, 1, rd, 1, 0, 0, 0, 0, 1);
  endtask

  task automatic lw(input int rd, input int rs);
    cyc(1, rs, 0, 1, 0, rd, 1, 1, 0, 0, 0, 1);
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = 0;
      for (int k = 0; k < 4; k++) pipe[c][k] = '0;
    end
    // first reset cycle unchecked: records are still unknown before it
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // ALU chain back to back, then with one bubble
    alu(3, 1, 2); alu(5, 3, 1); idle(3);
    alu(3, 1, 2); idle(1); alu(5, 3, 1); idle(3);
    // load-use: consumer held in ID until accepted
    lw(4, 1); alu(6, 2, 4); alu(6, 2, 4); alu(6, 2, 4); idle(4);
    // nearest writer wins
    alu(7, 1, 2); alu(7, 2, 3); alu(8, 7, 7); idle(3);
    // r0 writer and reader
    alu(0, 1, 2); alu(9, 0, 1); idle(3);
    // load then store of the loaded register (store data not read in ID)
    lw(2, 1); cyc(1, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 1); idle(4);
    // flush while a load-use hazard is pending
    lw(4, 1); cyc(1, 4, 4, 1, 1, 6, 1, 0, 0, 1, 0, 1); idle(3);
    // reset in the middle of traffic
    alu(3, 1, 2); lw(4, 3); cyc(1, 4, 1, 1, 1, 5, 1, 0, 0, 0, 1, 1); idle(3);
    // repeated load-use pairs push the narrow counter to saturation
    for (int i = 0; i < 6; i++) begin
      lw(5, 1); alu(6, 5, 5); alu(6, 5, 5); alu(6, 5, 5);
    end
    idle(3);

    // random traffic over a small register set to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      bit v  = ($urandom_range(0, 9) < 8);
      bit ld = ($urandom_range(0, 3) == 0);
      bit st = !ld && ($urandom_range(0, 4) == 0);
      cyc(v, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
          $urandom_range(0, 3), !st && ($urandom_range(0, 4) != 0), ld, st,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and load-use hazard controller for the in-order pipeline.
- Keeps its own shift-register record of every in-flight writer from EX through the last result stage.
- Produces ALU operand forward selects, store-data forwarding and the ID stall.
- Generalises fixed EX/MEM–MEM/WB forwarding to STAGES result stages, configurable load latency, r0 suppression, and adds a stall counter.

Parameters:
AW, 4, register address width
STAGES, 3, tracked records; index 0=EX, 1=MEM, 2=WB, … (min 2)
LOAD_LAT, 2, first stage index holding load data (1..STAGES-1)
ZERO_REG, 1, 1: register 0 never forwards and never stalls
CW, 16, stall counter width
FW, $clog2(STAGES), forward select width (derived; not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
id_valid  in  1  instruction present in ID
id_rs  in  AW  ID source A
id_rt  in  AW  ID source B / store data register
id_use_rs  in  1  ID reads rs
id_use_rt  in  1  ID reads rt
id_rd  in  AW  ID destination
id_wen  in  1  ID writes register file
id_load  in  1  ID is load
id_store  in  1  ID is store
flush  in  1  kill ID and EX (branch taken in EX)
stall  out  1  hold PC/IF/ID, bubble into EX
fwd_a  out  FW  EX operand A source: 0=regfile, k=stage k result
fwd_b  out  FW  EX operand B source, same encoding
fwd_c  out  1  MEM store data from stage-2 result
ex_valid  out  1  record 0 holds a live instruction
stall_cnt  out  CW  saturating count of stall cycles

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high.
- Record per stage: valid, rs, rt, rd, wen, load, store.
- Reset: all records cleared (valid=0). stall=0, fwd_a=fwd_b=0, fwd_c=0, ex_valid=0, stall_cnt=0. Applies mid-operation; in-flight records are discarded.
- Every cycle, records 1..STAGES-1 shift from their predecessor (rec[k] <= rec[k-1]). Lower stages never freeze.
- Record 0 load rule:
  - ID fields when id_valid & ~stall & ~flush.
  - Otherwise a bubble (valid=0).
- Live writer at stage k: valid & wen & (ZERO_REG=0 or rd≠0).
- stall (combinational from ID inputs and records): asserted when id_valid & ~flush and there is a stage j in 0..LOAD_LAT-2 where:
  - the record is a live writer with load=1, and
  - (id_use_rs & rs==rd) or (id_use_rt & rt==rd).
  - LOAD_LAT=1 never stalls.
  - With default parameters the stall lasts exactly 1 cycle. In general it lasts LOAD_LAT-1-j cycles.
- flush has priority over stall. On a flush cycle stall=0 and record 0 loads a bubble.
- fwd_a: smallest k in 1..STAGES-1 with rec[0].valid, rec[0] using rs, rec[k] a live writer, and rec[k].rd==rec[0].rs.
  - The nearest stage wins.
  - A load at k<LOAD_LAT is skipped; the stall rule guarantees this cannot occur.
  - 0 if none match.
- rec[0] tracks use flags (use_rs, use_rt), so records hold use flags as well.
- fwd_b: same as fwd_a on rt / use_rt.
- fwd_c: STAGES≥3 only, else tied 0. Asserted when:
  - rec[1] is a valid store, and
  - rec[2] is a live writer with rd==rec[1].rt, and
  - no live writer at rec[1]. A store does not write, so the condition reduces to the rec[2] match.
- fwd_a, fwd_b, fwd_c and ex_valid are combinational from registered records. They are valid in the same cycle the instruction sits in EX.
- stall_cnt increments on each cycle with stall=1 and holds at all-ones (saturating).
- Simultaneous events: flush + stall-condition → no stall, no count increment. Matches at several stages → lowest index wins.

Test Plan:
- ALU chain: ID add r3←…, then add r5←r3,r1 → in cycle 2 EX: fwd_a=1, fwd_b=0, stall=0. One bubble between them → fwd_a=2.
- Load-use: lw r4 followed by add r6←r2,r4 → stall=1 for exactly 1 cycle with a bubble in EX. Next EX: fwd_b=2. stall_cnt=1.
- Priority: add r7 at WB, sub r7 at MEM, EX reads r7 as rs and rt → fwd_a=fwd_b=1.
- r0 suppression: writer rd=0, consumer rs=0 → fwd_a=0, no stall. With ZERO_REG=0 → fwd_a=1.
- Store forwarding: lw r2 then sw r2 → stall=0. fwd_c=1 while sw in MEM and lw in WB.
- Flush/reset: lw r4 in EX and ID consumer with flush=1 → stall=0, ex_valid=0 next cycle. rst asserted mid-stream → all outputs 0 next edge, stall_cnt=0. LOAD_LAT=3, STAGES=4 regression: load-use stalls 2 cycles, then fwd=3.
